// File: rtl/pe_pkg.sv
// Shared types and saturation limits for the weight-stationary PE.
package pe_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_LOADING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_ACTIVE  = 2'd3
  } bank_state_e;

  localparam int unsigned LIMIT_W = 64;

  // Limits returned at LIMIT_W bits; callers truncate to their accumulator width.
  function automatic logic [LIMIT_W-1:0] sat_smax(input int unsigned acc_w);
    return (LIMIT_W'(1) << (acc_w - 1)) - LIMIT_W'(1);
  endfunction

  function automatic logic [LIMIT_W-1:0] sat_smin(input int unsigned acc_w);
    return ~sat_smax(acc_w);
  endfunction

  function automatic logic [LIMIT_W-1:0] sat_umax(input int unsigned acc_w);
    return (LIMIT_W'(1) << acc_w) - LIMIT_W'(1);
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Multiply-accumulate with optional saturation and a registered result stage.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int unsigned OP_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [OP_WIDTH-1:0]  w,
  input  logic [OP_WIDTH-1:0]  a,
  input  logic [ACC_WIDTH-1:0] psum,
  input  logic                 signed_mode,
  input  logic                 sat_en,
  input  logic                 in_last,
  output logic                 psum_valid,
  output logic [ACC_WIDTH-1:0] psum_out,
  output logic                 psum_last
);

  localparam int unsigned EW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(sat_smax(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(sat_smin(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'(sat_umax(ACC_WIDTH));

  logic [EW-1:0]        w_x, a_x, p_x, prod, sum;
  logic [ACC_WIDTH-1:0] res_c;

  // One guard bit above ACC_WIDTH is enough to hold any psum + product exactly.
  always_comb begin
    w_x   = {{(EW-OP_WIDTH){signed_mode & w[OP_WIDTH-1]}}, w};
    a_x   = {{(EW-OP_WIDTH){signed_mode & a[OP_WIDTH-1]}}, a};
    p_x   = {signed_mode & psum[ACC_WIDTH-1], psum};
    prod  = w_x * a_x;
    sum   = p_x + prod;
    res_c = sum[ACC_WIDTH-1:0];
    if (sat_en) begin
      if (signed_mode) begin
        if (!sum[EW-1] && sum[ACC_WIDTH-1])      res_c = SMAX;
        else if (sum[EW-1] && !sum[ACC_WIDTH-1]) res_c = SMIN;
      end else if (sum[EW-1]) begin
        res_c = UMAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psum_valid <= 1'b0;
      psum_last  <= 1'b0;
      psum_out   <= '0;
    end else begin
      psum_valid <= in_valid;
      psum_last  <= in_valid & in_last;
      if (in_valid) psum_out <= res_c;
    end
  end

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary PE with double-buffered weight banks feeding a 2-stage MAC.
module pe_ws_db
  import pe_pkg::*;
#(
  parameter int unsigned OP_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [OP_WIDTH-1:0]  w_data,
  input  logic                 w_last,
  input  logic                 iact_valid,
  output logic                 iact_ready,
  input  logic [OP_WIDTH-1:0]  iact,
  input  logic [ACC_WIDTH-1:0] psum_in,
  input  logic                 signed_mode,
  input  logic                 sat_en,
  output logic                 psum_valid,
  output logic [ACC_WIDTH-1:0] psum_out,
  output logic                 psum_last,
  output logic [1:0]           bank_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  bank_state_e          st   [2];
  bank_state_e          st_n [2];
  logic [LW-1:0]        len   [2];
  logic [LW-1:0]        len_n [2];
  logic [AW-1:0]        wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [OP_WIDTH-1:0]  mem [2][DEPTH];

  logic                 has_act, act_bank, oth_bank, ld_bank, ld_n;
  logic                 w_fire, iact_fire, rd_last;
  logic                 w_ready_n, iact_ready_n;
  logic [1:0]           bank_full_n;

  logic                 s1_valid, s1_signed, s1_sat, s1_last;
  logic [OP_WIDTH-1:0]  s1_w, s1_a;
  logic [ACC_WIDTH-1:0] s1_psum;

  // The bank not in use for compute is the load target; right after reset bank 0 loads first.
  function automatic logic pick_load(input bank_state_e s0, input bank_state_e s1);
    if (s0 == BANK_ACTIVE) return 1'b1;
    if (s1 == BANK_ACTIVE) return 1'b0;
    if (s0 == BANK_FULL)   return 1'b1;
    return 1'b0;
  endfunction

  always_comb begin
    has_act   = (st[0] == BANK_ACTIVE) || (st[1] == BANK_ACTIVE);
    act_bank  = (st[1] == BANK_ACTIVE);
    oth_bank  = ~act_bank;
    ld_bank   = pick_load(st[0], st[1]);
    w_fire    = w_valid && w_ready;
    iact_fire = iact_valid && iact_ready;
    rd_last   = (({1'b0, rd_ptr} + LW'(1)) == len[act_bank]);
  end

  // Bank control: load completion is applied before the wrap check so a bank finishing on the wrap edge swaps in.
  always_comb begin
    st_n[0]  = st[0];
    st_n[1]  = st[1];
    len_n[0] = len[0];
    len_n[1] = len[1];
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;

    if (w_fire) begin
      if (w_last || (wr_ptr == AW'(DEPTH - 1))) begin
        st_n[ld_bank]  = BANK_FULL;
        len_n[ld_bank] = LW'(wr_ptr) + LW'(1);
        wr_ptr_n       = '0;
      end else begin
        st_n[ld_bank]  = BANK_LOADING;
        wr_ptr_n       = wr_ptr + AW'(1);
      end
    end

    if (!has_act) begin
      if (st[0] == BANK_FULL) begin
        st_n[0]  = BANK_ACTIVE;
        rd_ptr_n = '0;
      end else if (st[1] == BANK_FULL) begin
        st_n[1]  = BANK_ACTIVE;
        rd_ptr_n = '0;
      end
    end else if (iact_fire) begin
      if (rd_last) begin
        rd_ptr_n = '0;
        if (st_n[oth_bank] == BANK_FULL) begin
          st_n[act_bank] = BANK_EMPTY;
          st_n[oth_bank] = BANK_ACTIVE;
        end
      end else begin
        rd_ptr_n = rd_ptr + AW'(1);
      end
    end

    ld_n           = pick_load(st_n[0], st_n[1]);
    w_ready_n      = (st_n[ld_n] == BANK_EMPTY) || (st_n[ld_n] == BANK_LOADING);
    iact_ready_n   = (st_n[0] == BANK_ACTIVE) || (st_n[1] == BANK_ACTIVE);
    bank_full_n[0] = (st_n[0] == BANK_FULL) || (st_n[0] == BANK_ACTIVE);
    bank_full_n[1] = (st_n[1] == BANK_FULL) || (st_n[1] == BANK_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= BANK_EMPTY;
        len[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      w_ready    <= 1'b1;
      iact_ready <= 1'b0;
      bank_full  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= st_n[i];
        len[i] <= len_n[i];
      end
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      w_ready    <= w_ready_n;
      iact_ready <= iact_ready_n;
      bank_full  <= bank_full_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) mem[ld_bank][wr_ptr] <= w_data;
  end

  // Stage 1: weight read and operand capture.
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= iact_fire;
  end

  always_ff @(posedge clk) begin
    if (iact_fire) begin
      s1_w      <= mem[act_bank][rd_ptr];
      s1_a      <= iact;
      s1_psum   <= psum_in;
      s1_signed <= signed_mode;
      s1_sat    <= sat_en;
      s1_last   <= rd_last;
    end
  end

  pe_mac_sat #(
    .OP_WIDTH  (OP_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (s1_valid),
    .w           (s1_w),
    .a           (s1_a),
    .psum        (s1_psum),
    .signed_mode (s1_signed),
    .sat_en      (s1_sat),
    .in_last     (s1_last),
    .psum_valid  (psum_valid),
    .psum_out    (psum_out),
    .psum_last   (psum_last)
  );

endmodule
